// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2
  } ctrl_state_t;

  // Consecutive high ticks required before a receive may start.
  localparam int unsigned IDLE_TICKS = 16;
  localparam int unsigned IDLE_CNT_W = $clog2(IDLE_TICKS + 1);

  // FIFO pointer width: one extra MSB separates full from empty.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Configuration, serial pin and bus-side read/status signals of the receiver.
interface uart_rx_ctrl_if #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 5
);

  logic             rx_in;
  logic             cfg_en;
  logic [DIV_W-1:0] cfg_div;
  logic             rd_en;
  logic             fifo_clr;
  logic             clr_err;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             overrun;
  logic             frame_err;
  logic             busy;

  modport master (
    output rx_in, cfg_en, cfg_div, rd_en, fifo_clr, clr_err,
    input  rd_data, rd_valid, fifo_count, overrun, frame_err, busy
  );

  modport slave (
    input  rx_in, cfg_en, cfg_div, rd_en, fifo_clr, clr_err,
    output rd_data, rd_valid, fifo_count, overrun, frame_err, busy
  );

endinterface

// File: rtl/uart_rx.sv
// 16x oversampling UART receive engine: start, DBIT data bits LSB first, stop.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic            smpl_tick,
  output logic            rx_idle,
  output logic [DBIT-1:0] dout
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {E_IDLE, E_START, E_DATA, E_STOP} eng_state_t;

  eng_state_t      r_state, w_state_nxt;
  logic [3:0]      r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic            r_rx_q;

  // State and datapath registers; previous rx level for falling-edge start detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= E_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_rx_q  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_rx_q  <= rx;
    end
  end

  // Frame sequencing; a start needs a falling edge so a low stop bit cannot retrigger.
  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_n_nxt      = r_n;
    w_b_nxt      = r_b;
    rx_done_tick = 1'b0;
    smpl_tick    = 1'b0;
    unique case (r_state)
      E_IDLE: begin
        if (r_rx_q && !rx) begin
          w_state_nxt = E_START;
          w_s_nxt     = '0;
        end
      end
      E_START: begin
        if (s_tick) begin
          if (r_s == 4'd7) begin
            w_s_nxt = '0;
            w_n_nxt = '0;
            w_state_nxt = rx ? E_IDLE : E_DATA;
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      E_DATA: begin
        if (s_tick) begin
          if (r_s == 4'd15) begin
            w_s_nxt   = '0;
            smpl_tick = 1'b1;
            w_b_nxt   = {rx, r_b[DBIT-1:1]};
            if (r_n == NW'(DBIT - 1)) w_state_nxt = E_STOP;
            else                      w_n_nxt     = r_n + NW'(1);
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      E_STOP: begin
        if (s_tick) begin
          if (r_s == 4'(SB_TICK - 1)) begin
            rx_done_tick = 1'b1;
            w_state_nxt  = E_IDLE;
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end
      default: w_state_nxt = E_IDLE;
    endcase
  end

  assign rx_idle = (r_state == E_IDLE);
  assign dout    = r_b;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick, pin sync, enable/arm sequencing, stop check, RX FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DBIT       = 8
) (
  input logic           clk,
  input logic           reset_n,
  uart_rx_ctrl_if.slave bus
);

  localparam int unsigned PW = fifo_ptr_w(FIFO_DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned DW = 8;

  logic [1:0]            r_sync;
  logic                  w_rx_s;
  logic [DIV_W-1:0]      r_tcnt;
  logic                  w_s_tick;
  ctrl_state_t           r_state, w_state_nxt;
  logic [IDLE_CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic                  r_eng_rst;
  logic                  w_rx_done, w_eng_idle;
  logic [DBIT-1:0]       w_dout;
  logic [DW-1:0]         w_din, w_head_nxt;
  logic [DW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
  logic [PW-1:0]         r_count;
  logic                  w_full, w_empty, w_push_req, w_push, w_pop;
  logic                  w_ovr_set, w_ferr_set;
  logic [DW-1:0]         r_rd_data;
  logic                  r_rd_valid, r_overrun, r_frame_err, r_busy;

  // Two-flop synchroniser on the serial pin, idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], bus.rx_in};
  end
  assign w_rx_s = r_sync[1];

  // Oversampling tick: period cfg_div+1 clocks, held clear while disabled.
  assign w_s_tick = (r_state != OFF) && (r_tcnt == bus.cfg_div);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        r_tcnt <= '0;
    else if (r_state == OFF || w_s_tick) r_tcnt <= '0;
    else                                 r_tcnt <= r_tcnt + DIV_W'(1);
  end

  // Controller state, idle counter and glitch-free engine reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= OFF;
      r_idle_cnt <= '0;
      r_eng_rst  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_eng_rst  <= (w_state_nxt != RUN);
    end
  end

  // Next state: arm on a full idle-line period so capture never starts mid-frame.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = '0;
    unique case (r_state)
      OFF: if (bus.cfg_en) w_state_nxt = ARM;
      ARM: begin
        w_idle_cnt_nxt = r_idle_cnt;
        if (!w_rx_s) begin
          w_idle_cnt_nxt = '0;
        end else if (w_s_tick) begin
          if (r_idle_cnt == IDLE_CNT_W'(IDLE_TICKS - 1)) begin
            w_state_nxt    = RUN;
            w_idle_cnt_nxt = '0;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + IDLE_CNT_W'(1);
          end
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = OFF;
    endcase
    if (!bus.cfg_en) w_state_nxt = OFF;
  end

  uart_rx #(
    .DBIT    (DBIT),
    .SB_TICK (16)
  ) u_rx (
    .clk          (clk),
    .reset        (r_eng_rst),
    .rx           (w_rx_s),
    .s_tick       (w_s_tick),
    .rx_done_tick (w_rx_done),
    .smpl_tick    (),
    .rx_idle      (w_eng_idle),
    .dout         (w_dout)
  );

  // FIFO control: stop-bit check, full/empty arbitration, flush priority, next head.
  always_comb begin
    w_din        = DW'(w_dout);
    w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_empty      = (r_wr_ptr == r_rd_ptr);
    w_push_req   = w_rx_done && w_rx_s;
    w_pop        = bus.rd_en && !w_empty && !bus.fifo_clr;
    w_push       = w_push_req && (!w_full || w_pop) && !bus.fifo_clr;
    w_ovr_set    = w_push_req && w_full && !w_pop && !bus.fifo_clr;
    w_ferr_set   = w_rx_done && !w_rx_s;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (bus.fifo_clr) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end
    w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0])) w_head_nxt = w_din;
    else                                                        w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
  end

  // FIFO storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_din;
  end

  // Pointers, registered head/count/valid, sticky flags (set beats clear), busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_rd_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) r_rd_data <= w_head_nxt;
      r_overrun   <= w_ovr_set  || (r_overrun   && !bus.clr_err);
      r_frame_err <= w_ferr_set || (r_frame_err && !bus.clr_err);
      r_busy      <= (r_state == RUN) && !w_eng_idle;
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.fifo_count = r_count;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the SoC UART. Generates the 16x oversampling tick from a programmable divisor and synchronises the asynchronous serial pin. Sequences the existing `uart_rx` engine through disable, line-idle arming and run, checks the stop bit, and buffers received bytes in a first-word-fallthrough FIFO with sticky overrun and framing-error flags for the bus-side register logic.

## Interface
- `DIV_W`, 16: divisor width.
- `FIFO_DEPTH`, 16: receive FIFO entries; must be a power of 2 and at least 2.
- `DBIT`, 8: data bits per frame, passed to `uart_rx`.
- `clk` in 1: system clock; the block has one clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `rx_in` in 1: asynchronous serial pin; idle level is high.
- `cfg_en` in 1: receiver enable.
- `cfg_div` in DIV_W: tick period is cfg_div+1 clocks, so baud = f_clk/(16·(cfg_div+1)).
- `rd_en` in 1: pop the FIFO head.
- `fifo_clr` in 1: synchronous FIFO flush.
- `clr_err` in 1: clear both sticky error flags.
- `rd_data` out 8: FIFO head; valid while `rd_valid`=1.
- `rd_valid` out 1: FIFO is non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `overrun` out 1: sticky flag; a byte was dropped because the FIFO was full.
- `frame_err` out 1: sticky flag; a stop bit was sampled low.
- `busy` out 1: state is RUN and the engine is not in idle.

## Operation
- Synchroniser: 2-flop chain on `rx_in`; both flops reset to 1. All internal logic uses the output `rx_s`.
- Tick counter `tcnt` (DIV_W bits):
  - Cleared in OFF.
  - Otherwise it counts up. `s_tick`=1 in the cycle `tcnt`==`cfg_div`, then `tcnt` returns to 0.
  - `cfg_div`=0 gives a tick every clock.
  - A divisor change takes effect on the next compare. If `tcnt` is already past the new value, the counter wraps at 2^DIV_W.
- Controller FSM, encoded as `ctrl_state_t`:
  - OFF: `uart_rx` is held in reset. Go to ARM when `cfg_en`=1.
  - ARM: `idle_cnt` counts `s_tick`s while `rx_s`=1 and clears on `rx_s`=0. Go to RUN at IDLE_TICKS (16) consecutive high ticks. Arming prevents capture starting mid-frame.
  - RUN: `uart_rx` reset is released.
  - Any state goes to OFF on `cfg_en`=0; this transition has priority.
- The engine reset is a registered signal, high in OFF and ARM, so the reset to `uart_rx` is glitch-free. It is also forced high asynchronously by `reset_n`=0.
- Frame check: on `rx_done_tick`, the stop bit is `rx_s` in the same cycle.
  - `rx_s`=1: push `dout`.
  - `rx_s`=0: discard the byte and set `frame_err`.
- FIFO: read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - Push when full: drop the byte and set `overrun`.
  - Push and pop in the same cycle when full: both occur; count is unchanged; no overrun.
  - Push and pop in the same cycle when empty: push only, since the pop is ignored.
  - `rd_en` when empty is ignored.
  - `fifo_clr` empties the FIFO and has priority over a push or pop in the same cycle.
- Sticky flags: if set and `clr_err` occur in the same cycle, the flag stays set (set wins).
- `cfg_en`=0 mid-frame aborts the frame; no push occurs. FIFO contents and flags are preserved.

## Timing
- Reset values:
  - `rd_valid`=0, `fifo_count`=0, `rd_data`=0.
  - `overrun`=0, `frame_err`=0, `busy`=0.
  - State OFF, `tcnt`=0, `idle_cnt`=0.
- Pin to `rx_s`: 2 clocks.
- `rx_done_tick` (combinational in `uart_rx`) to push takes effect at that clock edge. `rd_valid` and `rd_data` update in the next cycle.
- Pop: `rd_data` and `rd_valid` reflect the new head in the cycle after `rd_en`.
- ARM to RUN: at least 16·(cfg_div+1) clocks of continuous high line after entering ARM.
- Error flags assert in the cycle after the triggering event.

## Structure
- Package `uart_pkg`:
  - `ctrl_state_t` enum {OFF, ARM, RUN}.
  - Localparam IDLE_TICKS=16.
  - Helper function for the FIFO pointer width.
- One sub-module: `uart_rx` (existing engine). It is driven with `reset` = registered engine reset, `rx` = `rx_s`, and `s_tick` from the tick counter; `smpl_tick` is left unconnected.
- FIFO storage, pointers, flags and FSM are inline. Estimated size is about 200 lines.

## Test plan
- Reset, then `cfg_div`=3, `cfg_en`=1, line high:
  - RUN is reached after 64 clocks plus at most 4.
  - Send 0xA5 (bit = 64 clocks): `rd_valid`=1, `rd_data`=0xA5, `fifo_count`=1, no flags.
- Hold the line low through ARM, then release it:
  - ARM restarts the count and RUN is entered 64 clocks after release.
  - No spurious byte is received.
- Send 0x3C with the stop bit low: FIFO stays empty and `frame_err`=1.
  - `clr_err` clears it.
  - `clr_err` coincident with a new bad stop leaves `frame_err`=1.
- With `FIFO_DEPTH`=16, send 17 bytes 0x00–0x10 without popping:
  - `fifo_count`=16 and `overrun`=1.
  - Reads return 0x00–0x0F; 0x10 is lost.
- Full FIFO with `rd_en` pulsed in the `rx_done_tick` cycle: count stays 16, no overrun, and the new byte is stored last.
- Drop `cfg_en` mid-frame of 0x55, then `fifo_clr`; separately assert `reset_n`=0 mid-frame:
  - No push occurs.
  - After reset all outputs are at their reset values and the state is OFF.
